fsr_scan_sequencer: RTL and testbench
=====================================

FSR_SCAN_SEQUENCER -- requirements
Module: fsr_scan_sequencer

Interface
REQ-001 The block SHALL have the parameter SCAN_DIV, default 100000, meaning CLK100MHZ cycles between scan starts (minimum 64).
REQ-002 The block SHALL have the parameter THRESH, default 12'h800, meaning the 12-bit press threshold, inclusive.
REQ-003 The block SHALL have the parameter DEBOUNCE, default 4, meaning consecutive identical scan decisions required before the flags change (range 1-15).
REQ-004 The block SHALL have the parameter TIMEOUT, default 64, meaning the maximum cycles to wait for drdy.
REQ-005 Port CLK100MHZ SHALL be an input, width 1: the single clock, rising edge.
REQ-006 Port CPU_RESETN SHALL be an input, width 1: reset, asynchronous, active-low.
REQ-007 Port daddr SHALL be an output, width 7: XADC DRP address.
REQ-008 Port den SHALL be an output, width 1: DRP enable, one-cycle pulse.
REQ-009 Port dwe SHALL be an output, width 1: DRP write enable, tied 0.
REQ-010 Port drdy SHALL be an input, width 1: DRP read-data valid.
REQ-011 Port do_in SHALL be an input, width 16: DRP read data.
REQ-012 Ports ch0..ch3 SHALL each be an output, width 12: latest samples of vaux2, vaux3, vaux10 and vaux11.
REQ-013 Ports left_flag, right_flag and neither_flag SHALL each be an output, width 1: debounced direction, one-hot.
REQ-014 Port direction_cs SHALL be an output, width 1: 1 when right_flag is set, else 0.
REQ-015 Port scan_done SHALL be an output, width 1: one-cycle pulse at the end of each scan.
REQ-016 Port timeout_err SHALL be an output, width 1: sticky flag for a DRP timeout.
REQ-017 Port overrun_err SHALL be an output, width 1: sticky flag for a scan tick lost.

Function
REQ-018 A free-running tick counter SHALL count 0..SCAN_DIV-1 and assert a tick for one cycle when it wraps to 0.
REQ-019 The FSM states SHALL be IDLE, REQ, WAIT, NEXT and DECIDE.
REQ-020 The FSM SHALL move from IDLE to REQ on a tick or when a pending tick is set, with channel index 0.
REQ-021 In REQ, the block SHALL drive den=1 for exactly one cycle, with daddr = 0x12, 0x13, 0x1A or 0x1B for index 0-3, then go to WAIT.
REQ-022 In WAIT, on drdy=1 the block SHALL store do_in[15:4] into ch[index] on the same edge and go to NEXT.
REQ-023 In WAIT, if drdy has not arrived after TIMEOUT cycles, the block SHALL keep the previous ch[index], set timeout_err, and go to NEXT.
REQ-024 In NEXT, the block SHALL increment the index and go to REQ if index<3, else go to DECIDE.
REQ-025 A scan SHALL take 4 reads; with a 1-cycle drdy latency it SHALL complete in 13 cycles from the tick.
REQ-026 A drdy asserted in any state other than WAIT SHALL be ignored.
REQ-027 In DECIDE, the block SHALL compute Lp = (ch0>=THRESH)|(ch1>=THRESH) and Rp = (ch2>=THRESH)|(ch3>=THRESH).
REQ-028 The DECIDE candidate SHALL be LEFT if Lp&!Rp, RIGHT if Rp&!Lp, and NEITHER otherwise (both sides pressed or neither pressed).
REQ-029 A 4-bit stable counter SHALL increment (saturating at 15) when the candidate equals the previous candidate, else reload to 1; the previous candidate SHALL be updated every scan.
REQ-030 When the stable counter is >= DEBOUNCE, the flags SHALL take the candidate one cycle after DECIDE; otherwise the flags SHALL hold.
REQ-031 scan_done SHALL pulse in the cycle after DECIDE, coincident with any flag update, and the FSM SHALL then return to IDLE.
REQ-032 A tick that occurs while the FSM is not in IDLE SHALL set pending; pending SHALL be cleared when a scan starts from it.
REQ-033 A tick that occurs while pending is already set SHALL be dropped and SHALL set overrun_err.
REQ-034 The flags SHALL be exactly one-hot at all times.
REQ-035 timeout_err and overrun_err SHALL be cleared only by reset.

Reset
REQ-036 While CPU_RESETN=0, the block SHALL force immediately, without waiting for a clock: FSM=IDLE, den=0, daddr=0, dwe=0, ch0..ch3=0, neither_flag=1, left_flag=0, right_flag=0, direction_cs=0, scan_done=0, both error flags=0, tick counter=0, pending=0, stable counter=0, previous candidate=NEITHER.
REQ-037 A reset asserted mid-scan SHALL abandon the scan; after release, the first scan SHALL start at the next tick, SCAN_DIV cycles later.

Verification
REQ-038 The bench SHALL cover: SCAN_DIV=100, DRP model with drdy 1 cycle after den, ch0=0x900 and others 0x100 for 4 scans -> den pulses at 0x12, 0x13, 0x1A, 0x1B; left_flag=1 after the 4th scan_done, not before.
REQ-039 The bench SHALL cover: all channels at 0x900 (both sides pressed) -> neither_flag stays 1; direction_cs=0.
REQ-040 The bench SHALL cover: ch2 toggling 0x900/0x100 on alternate scans -> the flags never leave NEITHER.
REQ-041 The bench SHALL cover: the DRP model withholds drdy for vaux10 -> WAIT exits after 64 cycles, ch2 is unchanged, timeout_err=1, and the scan completes.
REQ-042 The bench SHALL cover: SCAN_DIV=64 with drdy latency 20 -> pending is set, and the second tick during the same scan sets overrun_err=1.
REQ-043 The bench SHALL cover: CPU_RESETN pulled low while in WAIT for channel 1 -> den=0 and neither_flag=1 immediately; after release, no den occurs until the next tick.

Source files
------------

// File: rtl/fsr_scan_sequencer.sv
// fsr_scan_sequencer
// Periodically reads four force-sensing-resistor channels from the XADC
// through its DRP port (vaux2, vaux3, vaux10, vaux11), then turns the
// left/right press pattern into a debounced one-hot direction.
//
// Ports
//   CLK100MHZ     clock, rising edge
//   CPU_RESETN    asynchronous active-low reset
//   daddr/den/dwe DRP request (read only, dwe tied low)
//   drdy/do_in    DRP read response
//   ch0..ch3      latest 12-bit samples of vaux2, vaux3, vaux10, vaux11
//   left_flag, right_flag, neither_flag   debounced direction, one-hot
//   direction_cs  1 while right_flag is set
//   scan_done     one-cycle pulse at the end of every scan
//   timeout_err   sticky, a DRP read never returned drdy
//   overrun_err   sticky, a scan tick was dropped
//
// state  | meaning
// IDLE   | waiting for a scan tick (or a pending one)
// REQ    | den pulse, daddr selects channel r_idx
// WAIT   | waiting for drdy, bounded by TIMEOUT cycles
// NEXT   | advance channel index or finish the reads
// DECIDE | classify press pattern, debounce, update flags
module fsr_scan_sequencer #(
    parameter int unsigned SCAN_DIV = 100000,
    parameter logic [11:0] THRESH   = 12'h800,
    parameter int unsigned DEBOUNCE = 4,
    parameter int unsigned TIMEOUT  = 64
) (
    input  logic        CLK100MHZ,
    input  logic        CPU_RESETN,
    output logic [6:0]  daddr,
    output logic        den,
    output logic        dwe,
    input  logic        drdy,
    input  logic [15:0] do_in,
    output logic [11:0] ch0,
    output logic [11:0] ch1,
    output logic [11:0] ch2,
    output logic [11:0] ch3,
    output logic        left_flag,
    output logic        right_flag,
    output logic        neither_flag,
    output logic        direction_cs,
    output logic        scan_done,
    output logic        timeout_err,
    output logic        overrun_err
);

    localparam int TICK_W = $clog2(SCAN_DIV);
    localparam int TO_W   = $clog2(TIMEOUT + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_DIV - 1);
    localparam logic [TO_W-1:0]   TO_LOAD   = TO_W'(TIMEOUT - 1);
    localparam logic [3:0]        DEB_MIN   = 4'(DEBOUNCE);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_NEXT, S_DECIDE} state_t;
    typedef enum logic [1:0] {C_NEITHER, C_LEFT, C_RIGHT} cand_t;

    state_t              r_state;
    logic [TICK_W-1:0]   r_tick_cnt;
    logic [TO_W-1:0]     r_wait_cnt;
    logic [1:0]          r_idx;
    logic [11:0]         r_ch [4];
    logic [6:0]          r_daddr;
    logic                r_den;
    logic                r_pending;
    logic [3:0]          r_stable;
    cand_t               r_prev_cand;
    logic                r_left;
    logic                r_right;
    logic                r_neither;
    logic                r_scan_done;
    logic                r_timeout_err;
    logic                r_overrun_err;

    logic                w_tick;
    logic                w_lp;
    logic                w_rp;
    cand_t               w_cand;
    logic [3:0]          w_stable_nxt;
    logic                w_do_unused;

    function automatic logic [6:0] chan_addr(input logic [1:0] idx);
        case (idx)
            2'd0:    return 7'h12;
            2'd1:    return 7'h13;
            2'd2:    return 7'h1A;
            default: return 7'h1B;
        endcase
    endfunction

    // The XADC result is left-justified; the low nibble is not used.
    assign w_do_unused = ^do_in[3:0];

    assign w_tick = (r_tick_cnt == TICK_LAST);

    assign w_lp = (r_ch[0] >= THRESH) | (r_ch[1] >= THRESH);
    assign w_rp = (r_ch[2] >= THRESH) | (r_ch[3] >= THRESH);
    assign w_cand = (w_lp && !w_rp) ? C_LEFT :
                    (w_rp && !w_lp) ? C_RIGHT : C_NEITHER;
    assign w_stable_nxt = (w_cand == r_prev_cand) ?
                          ((r_stable == 4'hF) ? 4'hF : r_stable + 4'd1) : 4'd1;

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            r_state       <= S_IDLE;
            r_wait_cnt    <= '0;
            r_idx         <= '0;
            for (int i = 0; i < 4; i++) r_ch[i] <= '0;
            r_daddr       <= '0;
            r_den         <= 1'b0;
            r_pending     <= 1'b0;
            r_stable      <= '0;
            r_prev_cand   <= C_NEITHER;
            r_left        <= 1'b0;
            r_right       <= 1'b0;
            r_neither     <= 1'b1;
            r_scan_done   <= 1'b0;
            r_timeout_err <= 1'b0;
            r_overrun_err <= 1'b0;
        end else begin
            r_den       <= 1'b0;
            r_scan_done <= 1'b0;

            // Only one tick can be queued behind a running scan.
            if (w_tick && (r_state != S_IDLE)) begin
                if (r_pending) r_overrun_err <= 1'b1;
                else           r_pending     <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_tick || r_pending) begin
                        // A fresh tick arriving while we consume a pending one
                        // stays queued for the following scan.
                        r_pending <= r_pending & w_tick;
                        r_idx     <= 2'd0;
                        r_daddr   <= chan_addr(2'd0);
                        r_den     <= 1'b1;
                        r_state   <= S_REQ;
                    end
                end
                S_REQ: begin
                    r_wait_cnt <= TO_LOAD;
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (drdy) begin
                        r_ch[r_idx] <= do_in[15:4];
                        r_state     <= S_NEXT;
                    end else if (r_wait_cnt == '0) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= S_NEXT;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 1'b1;
                    end
                end
                S_NEXT: begin
                    if (r_idx != 2'd3) begin
                        r_idx   <= r_idx + 2'd1;
                        r_daddr <= chan_addr(r_idx + 2'd1);
                        r_den   <= 1'b1;
                        r_state <= S_REQ;
                    end else begin
                        r_state <= S_DECIDE;
                    end
                end
                S_DECIDE: begin
                    r_prev_cand <= w_cand;
                    r_stable    <= w_stable_nxt;
                    if (w_stable_nxt >= DEB_MIN) begin
                        r_left    <= (w_cand == C_LEFT);
                        r_right   <= (w_cand == C_RIGHT);
                        r_neither <= (w_cand == C_NEITHER);
                    end
                    r_scan_done <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign daddr        = r_daddr;
    assign den          = r_den;
    assign dwe          = 1'b0;
    assign ch0          = r_ch[0];
    assign ch1          = r_ch[1];
    assign ch2          = r_ch[2];
    assign ch3          = r_ch[3];
    assign left_flag    = r_left;
    assign right_flag   = r_right;
    assign neither_flag = r_neither;
    assign direction_cs = r_right;
    assign scan_done    = r_scan_done;
    assign timeout_err  = r_timeout_err;
    assign overrun_err  = r_overrun_err;

endmodule

// File: tb/tb_fsr_scan_sequencer.sv
module tb_fsr_scan_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    logic rst_a = 1'b0;
    logic rst_b = 1'b0;

    // instance A: SCAN_DIV=100, drdy latency 1
    logic [6:0]  daddr_a;
    logic        den_a, dwe_a, drdy_a;
    logic [15:0] do_a;
    logic [11:0] c0_a, c1_a, c2_a, c3_a;
    logic        l_a, r_a, n_a, dcs_a, sd_a, te_a, oe_a;

    // instance B: SCAN_DIV=64, drdy latency 20
    logic [6:0]  daddr_b;
    logic        den_b, dwe_b, drdy_b;
    logic [15:0] do_b;
    logic [11:0] c0_b, c1_b, c2_b, c3_b;
    logic        l_b, r_b, n_b, dcs_b, sd_b, te_b, oe_b;

    fsr_scan_sequencer #(.SCAN_DIV(100)) dut_a (
        .CLK100MHZ(clk), .CPU_RESETN(rst_a),
        .daddr(daddr_a), .den(den_a), .dwe(dwe_a), .drdy(drdy_a), .do_in(do_a),
        .ch0(c0_a), .ch1(c1_a), .ch2(c2_a), .ch3(c3_a),
        .left_flag(l_a), .right_flag(r_a), .neither_flag(n_a), .direction_cs(dcs_a),
        .scan_done(sd_a), .timeout_err(te_a), .overrun_err(oe_a)
    );

    fsr_scan_sequencer #(.SCAN_DIV(64)) dut_b (
        .CLK100MHZ(clk), .CPU_RESETN(rst_b),
        .daddr(daddr_b), .den(den_b), .dwe(dwe_b), .drdy(drdy_b), .do_in(do_b),
        .ch0(c0_b), .ch1(c1_b), .ch2(c2_b), .ch3(c3_b),
        .left_flag(l_b), .right_flag(r_b), .neither_flag(n_b), .direction_cs(dcs_b),
        .scan_done(sd_b), .timeout_err(te_b), .overrun_err(oe_b)
    );

    function automatic logic [1:0] addr_idx(input logic [6:0] a);
        case (a)
            7'h12:   return 2'd0;
            7'h13:   return 2'd1;
            7'h1A:   return 2'd2;
            7'h1B:   return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    // DRP model A: drdy lat_a cycles after den, optional withheld channel
    logic [11:0] val_a [4];
    logic [5:0]  lat_a = 6'd1;
    logic [5:0]  cnt_a = 6'd0;
    logic [6:0]  last_a = 7'h12;
    logic        hold_en_a = 1'b0;
    logic [1:0]  hold_idx_a = 2'd0;
    logic        extra_a = 1'b0;

    always @(posedge clk) begin
        if (!rst_a) cnt_a <= 6'd0;
        else if (den_a && !(hold_en_a && addr_idx(daddr_a) == hold_idx_a)) begin
            cnt_a  <= lat_a;
            last_a <= daddr_a;
        end else if (cnt_a != 6'd0) cnt_a <= cnt_a - 6'd1;
    end
    assign drdy_a = (cnt_a == 6'd1) || extra_a;
    assign do_a   = extra_a ? 16'hFFF0 : {val_a[addr_idx(last_a)], 4'h5};

    // DRP model B
    logic [11:0] val_b [4];
    logic [5:0]  lat_b = 6'd20;
    logic [5:0]  cnt_b = 6'd0;
    logic [6:0]  last_b = 7'h12;

    always @(posedge clk) begin
        if (!rst_b) cnt_b <= 6'd0;
        else if (den_b) begin
            cnt_b  <= lat_b;
            last_b <= daddr_b;
        end else if (cnt_b != 6'd0) cnt_b <= cnt_b - 6'd1;
    end
    assign drdy_b = (cnt_b == 6'd1);
    assign do_b   = {val_b[addr_idx(last_b)], 4'h5};

    // den monitor for instance A
    logic [6:0] log_addr [$];
    int         log_cyc  [$];
    always @(posedge clk) begin
        if (rst_a && den_a) begin
            log_addr.push_back(daddr_a);
            log_cyc.push_back(cyc);
        end
    end

    function automatic logic [27:0] pack_log();
        if (log_addr.size() != 4) return 28'h0;
        return {log_addr[0], log_addr[1], log_addr[2], log_addr[3]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_done_a(output int sd_cyc);
        bit ok;
        ok = 1'b0;
        sd_cyc = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (sd_a) begin
                ok = 1'b1;
                sd_cyc = cyc;
                break;
            end
        end
        check("scan_done_a seen", 64'(ok), 64'd1);
    endtask

    task automatic load_vals(input logic [11:0] v0, v1, v2, v3);
        val_a[0] = v0; val_a[1] = v1; val_a[2] = v2; val_a[3] = v3;
    endtask

    typedef struct {
        bit          rst;
        logic [11:0] v0, v1, v2, v3;
        bit          el, er, en;
    } vec_t;

    vec_t vecs [23];

    initial begin
        int  sdc;
        int  n;
        bit  found;

        vecs[0]  = '{1'b1, 12'h900, 12'h100, 12'h100, 12'h100, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, 12'h900, 12'h100, 12'h100, 12'h100, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 12'h900, 12'h100, 12'h100, 12'h100, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 12'h900, 12'h100, 12'h100, 12'h100, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 12'h900, 12'h900, 12'h900, 12'h900, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 12'h900, 12'h900, 12'h900, 12'h900, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 12'h900, 12'h900, 12'h900, 12'h900, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 12'h900, 12'h900, 12'h900, 12'h900, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 12'h100, 12'h100, 12'h900, 12'h100, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 12'h100, 12'h100, 12'h100, 12'h100, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 12'h100, 12'h100, 12'h900, 12'h100, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 12'h100, 12'h100, 12'h100, 12'h100, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 12'h100, 12'h100, 12'h900, 12'h100, 1'b0, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 12'h100, 12'h100, 12'h100, 12'h100, 1'b0, 1'b0, 1'b1};
        vecs[14] = '{1'b1, 12'h100, 12'h100, 12'h100, 12'h900, 1'b0, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 12'h100, 12'h100, 12'h100, 12'h900, 1'b0, 1'b0, 1'b1};
        vecs[16] = '{1'b0, 12'h100, 12'h100, 12'h100, 12'h900, 1'b0, 1'b0, 1'b1};
        vecs[17] = '{1'b0, 12'h100, 12'h100, 12'h100, 12'h900, 1'b0, 1'b1, 1'b0};
        vecs[18] = '{1'b0, 12'h7FF, 12'h100, 12'h100, 12'h100, 1'b0, 1'b1, 1'b0};
        vecs[19] = '{1'b0, 12'h100, 12'h800, 12'h100, 12'h100, 1'b0, 1'b1, 1'b0};
        vecs[20] = '{1'b0, 12'h100, 12'h800, 12'h100, 12'h100, 1'b0, 1'b1, 1'b0};
        vecs[21] = '{1'b0, 12'h100, 12'h800, 12'h100, 12'h100, 1'b0, 1'b1, 1'b0};
        vecs[22] = '{1'b0, 12'h100, 12'h800, 12'h100, 12'h100, 1'b1, 1'b0, 1'b0};

        load_vals(12'h100, 12'h100, 12'h100, 12'h100);
        for (int i = 0; i < 4; i++) val_b[i] = 12'h100;

        // reset state
        repeat (3) @(negedge clk);
        check("rst flags", {l_a, r_a, n_a, dcs_a}, 4'b0010);
        check("rst drp", {den_a, dwe_a, daddr_a}, 9'h0);
        check("rst ch", {c0_a, c1_a, c2_a, c3_a}, 48'h0);
        check("rst misc", {sd_a, te_a, oe_a}, 3'b000);

        // table-driven scans
        for (int i = 0; i < 23; i++) begin
            if (vecs[i].rst) begin
                @(negedge clk);
                rst_a = 1'b0;
                repeat (2) @(negedge clk);
                rst_a = 1'b1;
            end
            load_vals(vecs[i].v0, vecs[i].v1, vecs[i].v2, vecs[i].v3);
            log_addr.delete();
            log_cyc.delete();
            wait_done_a(sdc);
            check($sformatf("vec%0d flags", i), {l_a, r_a, n_a, dcs_a},
                  {vecs[i].el, vecs[i].er, vecs[i].en, vecs[i].er});
            check($sformatf("vec%0d ch", i), {c0_a, c1_a, c2_a, c3_a},
                  {vecs[i].v0, vecs[i].v1, vecs[i].v2, vecs[i].v3});
            check($sformatf("vec%0d daddr seq", i), pack_log(),
                  {7'h12, 7'h13, 7'h1A, 7'h1B});
            check($sformatf("vec%0d scan length", i),
                  64'(log_cyc.size() > 0 ? sdc - log_cyc[0] : -1), 64'd13);
            @(negedge clk);
            check($sformatf("vec%0d scan_done width", i), 64'(sd_a), 64'd0);
        end

        // stray drdy while idle must not touch the samples
        extra_a = 1'b1;
        repeat (3) @(negedge clk);
        extra_a = 1'b0;
        check("stray drdy ch", {c0_a, c1_a, c2_a, c3_a}, {12'h100, 12'h800, 12'h100, 12'h100});

        // DRP timeout on vaux10
        check("pre timeout_err", 64'(te_a), 64'd0);
        hold_en_a = 1'b1;
        hold_idx_a = 2'd2;
        load_vals(12'h900, 12'h100, 12'hABC, 12'h100);
        log_addr.delete();
        log_cyc.delete();
        wait_done_a(sdc);
        check("timeout_err set", 64'(te_a), 64'd1);
        check("timeout ch", {c0_a, c1_a, c2_a, c3_a}, {12'h900, 12'h100, 12'h100, 12'h100});
        check("timeout daddr seq", pack_log(), {7'h12, 7'h13, 7'h1A, 7'h1B});
        check("timeout wait len", 64'(log_cyc.size() == 4 ? log_cyc[3] - log_cyc[2] : -1), 64'd66);
        hold_en_a = 1'b0;
        load_vals(12'h900, 12'h100, 12'h100, 12'h100);
        wait_done_a(sdc);
        check("timeout_err sticky", 64'(te_a), 64'd1);
        check("overrun_err a", 64'(oe_a), 64'd0);
        check("pre-reset flags", {l_a, r_a, n_a, dcs_a}, 4'b1000);

        // reset while waiting for channel 1
        found = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (den_a && daddr_a == 7'h13) begin
                found = 1'b1;
                break;
            end
        end
        check("den ch1 seen", 64'(found), 64'd1);
        @(posedge clk);
        #2;
        rst_a = 1'b0;
        #1;
        check("async rst flags", {l_a, r_a, n_a, dcs_a}, 4'b0010);
        check("async rst den", {den_a, daddr_a}, 8'h0);
        check("async rst ch", {c0_a, c1_a, c2_a, c3_a}, 48'h0);
        check("async rst err", {te_a, oe_a}, 2'b00);
        repeat (2) @(negedge clk);
        rst_a = 1'b1;
        n = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            n++;
            if (den_a) break;
        end
        check("first den after reset", 64'(n), 64'd100);

        // instance B: slow drdy, pending and overrun
        @(negedge clk);
        rst_b = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (sd_b) begin
                found = 1'b1;
                break;
            end
        end
        check("b scan_done seen", 64'(found), 64'd1);
        check("b errs after scan1", {te_b, oe_b}, 2'b00);
        @(negedge clk);
        check("b pending restart", {den_b, daddr_b}, {1'b1, 7'h12});
        found = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (oe_b) begin
                found = 1'b1;
                break;
            end
        end
        check("b overrun_err", 64'(found), 64'd1);
        check("b timeout_err", 64'(te_b), 64'd0);
        check("b flags", {l_b, r_b, n_b, dcs_b}, 4'b0010);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
